// File: rtl/epl_rx_parser.sv
// Ethernet Powerlink receive parser: strips preamble/SFD, writes frame
// bytes with their index, flags SoC frames and reports length/error.
module epl_rx_parser #(
  parameter int          L       = 10,
  parameter logic [15:0] ETHTYPE = 16'h88AB,
  parameter logic [6:0]  MSG_SOC = 7'h01,
  parameter int          MIN_LEN = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_dv,
  input  logic         rx_en,
  input  logic [7:0]   rx_data,
  output logic [7:0]   data,
  output logic [L-1:0] adress,
  output logic         we,
  output logic         head_done,
  output logic         soc,
  output logic         frame_done,
  output logic [L-1:0] frame_len,
  output logic         frame_err
);

  typedef enum logic [2:0] {
    IDLE,
    SFD_HUNT,
    HDR,
    PAYLOAD,
    DROP
  } state_t;

  localparam logic [L-1:0] IDX_MAX = '1;
  localparam logic [31:0]  MIN_U   = MIN_LEN;

  state_t       state;
  logic [L-1:0] idx;
  logic         full;
  logic         ovf;
  logic         eth_ok;
  logic         fresh;

  logic         acc;
  logic [L-1:0] len_w;
  logic         short_w;

  assign acc     = rx_dv & rx_en;
  assign len_w   = full ? IDX_MAX : idx;
  assign short_w = 32'(len_w) < MIN_U;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      full       <= 1'b0;
      ovf        <= 1'b0;
      eth_ok     <= 1'b0;
      fresh      <= 1'b1;
      data       <= '0;
      adress     <= '0;
      we         <= 1'b0;
      head_done  <= 1'b0;
      soc        <= 1'b0;
      frame_done <= 1'b0;
      frame_len  <= '0;
      frame_err  <= 1'b0;
    end else begin
      fresh      <= 1'b0;
      we         <= 1'b0;
      head_done  <= 1'b0;
      frame_done <= 1'b0;
      if (frame_done) soc <= 1'b0;
      unique case (state)
        IDLE, SFD_HUNT: begin
          // a frame already in flight at reset release is ignored
          if (!rx_dv) begin
            state <= IDLE;
          end else if (fresh) begin
            state <= DROP;
          end else if (acc) begin
            if (rx_data == 8'h55) begin
              state <= SFD_HUNT;
            end else if (rx_data == 8'hD5) begin
              state  <= HDR;
              idx    <= '0;
              full   <= 1'b0;
              ovf    <= 1'b0;
              eth_ok <= 1'b1;
            end else begin
              state <= DROP;
            end
          end else begin
            state <= SFD_HUNT;
          end
        end
        HDR, PAYLOAD: begin
          if (!rx_dv) begin
            frame_done <= 1'b1;
            frame_len  <= len_w;
            frame_err  <= short_w | ovf | (state == HDR);
            state      <= IDLE;
          end else if (acc) begin
            if (full) begin
              ovf <= 1'b1;
            end else begin
              we     <= 1'b1;
              data   <= rx_data;
              adress <= idx;
              if (idx == IDX_MAX) full <= 1'b1;
              else idx <= idx + L'(1);
              if (state == HDR) begin
                if (idx == L'(12))
                  eth_ok <= eth_ok & (rx_data == ETHTYPE[15:8]);
                if (idx == L'(13))
                  eth_ok <= eth_ok & (rx_data == ETHTYPE[7:0]);
                if (idx == L'(14)) begin
                  head_done <= 1'b1;
                  soc       <= eth_ok & (rx_data[6:0] == MSG_SOC);
                  state     <= PAYLOAD;
                end
              end
            end
          end
        end
        DROP: begin
          if (!rx_dv) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/epl_rx_parser.md
EPL_RX_PARSER -- requirements
Module: epl_rx_parser

Interface
REQ-001 Parameter L, default 10: width of the frame byte address.
REQ-002 Parameter ETHTYPE, default 16'h88AB: EtherType that identifies an Ethernet Powerlink frame.
REQ-003 Parameter MSG_SOC, default 7'h01: Powerlink MessageType value for Start Of Cycle (SoC).
REQ-004 Parameter MIN_LEN, default 64: minimum legal frame length in bytes, FCS included.
REQ-005 clk  input  1  single clock; all logic is on the rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-007 rx_dv  input  1  frame envelope from the MII byte assembler; high for preamble, SFD, frame and FCS.
REQ-008 rx_en  input  1  byte strobe; rx_data is valid when rx_en=1 and rx_dv=1.
REQ-009 rx_data  input  8  received byte.
REQ-010 data  output  8  frame byte to the buffer and time extractors.
REQ-011 adress  output  L  frame byte index; 0 = first destination-MAC byte after the SFD.
REQ-012 we  output  1  write strobe for data and adress; one cycle per byte.
REQ-013 head_done  output  1  one-cycle pulse: header (bytes 0..14) complete.
REQ-014 soc  output  1  frame is a Powerlink SoC; valid from head_done until frame end.
REQ-015 frame_done  output  1  one-cycle pulse at frame end.
REQ-016 frame_len  output  L  count of frame bytes accepted (FCS included), valid with frame_done.
REQ-017 frame_err  output  1  error status, valid with frame_done.

Function
REQ-018 FSM states: IDLE, SFD_HUNT, HDR, PAYLOAD, DROP.
REQ-019 IDLE: rx_dv=1 goes to SFD_HUNT; a byte accepted in the same cycle is evaluated as a preamble byte.
REQ-020 SFD_HUNT: byte 0x55 stays in SFD_HUNT; 0xD5 goes to HDR with byte index 0; any other byte goes to DROP; rx_dv=0 returns to IDLE with no frame_done.
REQ-021 Byte accepted in HDR or PAYLOAD at cycle t: at t+1 the block drives we=1, data=byte and adress=index; the index then increments.
REQ-022 we is 0 in every cycle without an accepted byte; gaps in rx_en are allowed.
REQ-023 HDR header check, producing soc:
- index 12 = ETHTYPE[15:8];
- index 13 = ETHTYPE[7:0];
- index 14: rx_data[6:0] = MSG_SOC.
REQ-024 head_done pulses in the same cycle as the we for adress 14; soc is 1 in that cycle if all three checks pass, else 0; FSM goes to PAYLOAD.
REQ-025 soc, once set, holds until the cycle after frame_done; it is 0 at all other times.
REQ-026 When the index reaches 2^L-1, later bytes produce no we; the index saturates and the overflow flag is set.
REQ-027 rx_dv falling in HDR or PAYLOAD: frame_done pulses one cycle after the last byte's we (or the next cycle if no byte is pending); FSM returns to IDLE.
REQ-028 frame_len equals the number of bytes accepted in HDR/PAYLOAD, saturating at 2^L-1.
REQ-029 frame_err=1 if any of the following holds:
- frame_len < MIN_LEN;
- overflow occurred;
- rx_dv fell before index 14 (in this case head_done never pulses).
REQ-030 DROP: no we, head_done or frame_done; the FSM waits for rx_dv=0, then returns to IDLE.
REQ-031 rx_dv rising and falling in the same cycle cannot occur; the block does not detect it.

Reset
REQ-032 While rst=0, every output is 0 (data, adress, frame_len included) and the FSM is IDLE.
REQ-033 Reset asserted mid-frame aborts the frame: no frame_done and no further we.
REQ-034 If rx_dv=1 when rst is released, the block enters DROP and ignores that frame.

Verification
REQ-035 SoC frame, 64 bytes after 7x0x55+0xD5, bytes 12..14 = 0x88,0xAB,0x01, bytes 36..43 = 0x11..0x88 -> 64 we pulses with adress 0..63; head_done=1 and soc=1 on the adress 14 cycle; adress 36..43 carry 0x11..0x88; frame_done with frame_len=64 and frame_err=0.
REQ-036 Same frame with byte 14 = 0x03 (PReq) -> head_done pulses with soc=0; frame_err=0.
REQ-037 rx_dv dropped after index 10 -> 11 we pulses and no head_done; frame_done with frame_len=11 and frame_err=1.
REQ-038 Preamble 0x55,0x55,0x5D -> DROP: zero we pulses and no frame_done until rx_dv=0; the next valid frame parses normally.
REQ-039 L=6 and a 70-byte frame -> we for adress 0..63 only; frame_len=63 and frame_err=1.
REQ-040 rst pulsed low at byte 20, rx_dv held high through release -> no we or frame_done for the rest of that frame; the next frame is parsed fully.
